// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffer: payload field
// layout, the NOP payload, and the buffer state encoding.
package pipe_stage_buf_pkg;

   // Payload field widths
   localparam int REG_BUS_W       = 32;
   localparam int REG_ADDR_BUS_W  = 5;
   localparam int INST_TYPE_BUS_W = 6;
   localparam int INST_ADDR_BUS_W = 32;

   // Full payload: rs1 + rs2 + rd_we + rd_addr + inst_type + imm + pc
   localparam int PIPE_DATA_W = REG_BUS_W + REG_BUS_W + 1 + REG_ADDR_BUS_W
                              + INST_TYPE_BUS_W + REG_BUS_W + INST_ADDR_BUS_W;

   // Field bit offsets (LSB of each field) used by the stages that pack/unpack
   localparam int OFF_PC        = 0;
   localparam int OFF_IMM       = OFF_PC + INST_ADDR_BUS_W;
   localparam int OFF_INST_TYPE = OFF_IMM + REG_BUS_W;
   localparam int OFF_RD_ADDR   = OFF_INST_TYPE + INST_TYPE_BUS_W;
   localparam int OFF_RD_WE     = OFF_RD_ADDR + REG_ADDR_BUS_W;
   localparam int OFF_RS2       = OFF_RD_WE + 1;
   localparam int OFF_RS1       = OFF_RS2 + REG_BUS_W;

   // NOP field values; all zero, so the NOP payload is all zero
   localparam logic                       WRITE_DISABLE  = 1'b0;
   localparam logic [REG_ADDR_BUS_W-1:0]  NOP_REG_ADDR   = '0;
   localparam logic [INST_TYPE_BUS_W-1:0] NOP_INST_TYPE  = '0;
   localparam logic [PIPE_DATA_W-1:0]     NOP_PAYLOAD_DEF = '0;

   // Buffer states; the encoding doubles as the occupancy count
   typedef enum logic [1:0] {
      STATE_EMPTY = 2'd0,
      STATE_BUSY  = 2'd1,
      STATE_FULL  = 2'd2
   } buf_state_e;

   // Number of entries held in a given state
   function automatic logic [1:0] occ_of(input buf_state_e s);
      case (s)
         STATE_BUSY: occ_of = 2'd1;
         STATE_FULL: occ_of = 2'd2;
         default:    occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One payload register with load enable and a clear-to-NOP input.
// Clear wins over load so a flush always leaves a harmless NOP behind.
module pipe_slot #(
   parameter int               DATA_W      = 140,
   parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Payload register: reset/clear to NOP, otherwise load when enabled
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         q <= NOP_PAYLOAD;
      end else if (clear) begin
         q <= NOP_PAYLOAD;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready flow control, synchronous
// flush and an optional second (skid) entry.
//
// Handshake: a word moves across an interface on a rising clk_in edge when
// valid and ready are both high at that edge; in_data is ignored while
// in_ready is low, and out_valid/out_data hold steady while out_valid is high
// and out_ready is low. A payload offered together with flush_in is dropped.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int                DATA_W      = PIPE_DATA_W,
   parameter bit                SKID_EN     = 1'b1,
   parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush_in,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occupancy
);

   buf_state_e        state_q;
   buf_state_e        state_d;
   logic              in_ready_q;
   logic              accept_in;
   logic              accept_out;
   logic              out_load;
   logic              out_clr;
   logic              out_from_skid;
   logic              skid_load;
   logic              skid_clr;
   logic [DATA_W-1:0] out_d;
   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] skid_q;

   assign out_valid  = (state_q != STATE_EMPTY);
   // Skid mode uses a registered ready; single-slot mode passes ready through
   assign in_ready   = SKID_EN ? in_ready_q : (!out_valid || out_ready);
   assign accept_in  = in_valid && in_ready && !flush_in;
   assign accept_out = out_valid && out_ready;
   assign out_d      = out_from_skid ? skid_q : in_data;
   assign out_data   = out_q;
   assign occupancy  = occ_of(state_q);

   // State register and registered ready (low only when heading into FULL)
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= STATE_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != STATE_FULL);
      end
   end

   // Next state and slot controls; flush overrides every transfer
   always_comb begin
      state_d       = state_q;
      out_load      = 1'b0;
      out_clr       = 1'b0;
      out_from_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      case (state_q)
         STATE_EMPTY: begin
            if (accept_in) begin
               state_d  = STATE_BUSY;
               out_load = 1'b1;
            end
         end
         STATE_BUSY: begin
            if (accept_in && accept_out) begin
               out_load = 1'b1;
            end else if (accept_in && SKID_EN) begin
               state_d   = STATE_FULL;
               skid_load = 1'b1;
            end else if (accept_out) begin
               state_d = STATE_EMPTY;
               out_clr = 1'b1;
            end
         end
         STATE_FULL: begin
            if (accept_out) begin
               state_d       = STATE_BUSY;
               out_load      = 1'b1;
               out_from_skid = 1'b1;
               skid_clr      = 1'b1;
            end
         end
         default: begin
            state_d = STATE_EMPTY;
            out_clr = 1'b1;
         end
      endcase
      if (flush_in) begin
         state_d   = STATE_EMPTY;
         out_load  = 1'b0;
         skid_load = 1'b0;
         out_clr   = 1'b1;
         skid_clr  = 1'b1;
      end
   end

   pipe_slot #(
      .DATA_W      (DATA_W),
      .NOP_PAYLOAD (NOP_PAYLOAD)
   ) u_out_slot (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (out_clr),
      .load   (out_load),
      .d      (out_d),
      .q      (out_q)
   );

   pipe_slot #(
      .DATA_W      (DATA_W),
      .NOP_PAYLOAD (NOP_PAYLOAD)
   ) u_skid_slot (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (skid_clr),
      .load   (skid_load),
      .d      (in_data),
      .q      (skid_q)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one skid instance (a_*) and one single-slot
// instance (b_*), each compared every cycle against a queue model, plus
// directed literal expectations.
module tb_pipe_stage_buf;

   localparam int W = 140;
   localparam logic [W-1:0] NOP = '0;

   logic         clk_in   = 1'b0;
   logic         rst_in   = 1'b1;

   logic         a_flush  = 1'b0;
   logic         a_iv     = 1'b0;
   logic [W-1:0] a_id     = '0;
   logic         a_ordy   = 1'b0;
   logic         a_ir;
   logic         a_ov;
   logic [W-1:0] a_od;
   logic [1:0]   a_occ;

   logic         b_flush  = 1'b0;
   logic         b_iv     = 1'b0;
   logic [W-1:0] b_id     = '0;
   logic         b_ordy   = 1'b0;
   logic         b_ir;
   logic         b_ov;
   logic [W-1:0] b_od;
   logic [1:0]   b_occ;

   int checks = 0;
   int errors = 0;

   // Model state: accepted-but-not-delivered words, oldest first
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp0_q[$];
   logic         m_ready = 1'b0;

   pipe_stage_buf #(.DATA_W(W), .SKID_EN(1'b1), .NOP_PAYLOAD(NOP)) dut_a (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush_in  (a_flush),
      .in_valid  (a_iv),
      .in_data   (a_id),
      .in_ready  (a_ir),
      .out_valid (a_ov),
      .out_data  (a_od),
      .out_ready (a_ordy),
      .occupancy (a_occ)
   );

   pipe_stage_buf #(.DATA_W(W), .SKID_EN(1'b0), .NOP_PAYLOAD(NOP)) dut_b (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush_in  (b_flush),
      .in_valid  (b_iv),
      .in_data   (b_id),
      .in_ready  (b_ir),
      .out_valid (b_ov),
      .out_data  (b_od),
      .out_ready (b_ordy),
      .occupancy (b_occ)
   );

   // Clock
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Queue model of both buffers: FIFO of up to 2 (skid) or 1 (single slot)
   always @(posedge clk_in or posedge rst_in) begin
      bit ai, ao, ready0;
      if (rst_in) begin
         exp_q.delete();
         exp0_q.delete();
         m_ready = 1'b0;
      end else begin
         ai = a_iv && m_ready && !a_flush;
         ao = (exp_q.size() != 0) && a_ordy;
         if (ao) void'(exp_q.pop_front());
         if (a_flush) exp_q.delete();
         else if (ai) exp_q.push_back(a_id);
         m_ready = (exp_q.size() != 2);

         ready0 = (exp0_q.size() == 0) || b_ordy;
         ai = b_iv && ready0 && !b_flush;
         ao = (exp0_q.size() != 0) && b_ordy;
         if (ao) void'(exp0_q.pop_front());
         if (b_flush) exp0_q.delete();
         else if (ai) exp0_q.push_back(b_id);
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk_in) begin
      check("a_out_valid", W'(a_ov), W'(exp_q.size() != 0));
      check("a_out_data", a_od, (exp_q.size() != 0) ? exp_q[0] : NOP);
      check("a_occupancy", W'(a_occ), W'(exp_q.size()));
      check("a_in_ready", W'(a_ir), W'(m_ready));
      check("b_out_valid", W'(b_ov), W'(exp0_q.size() != 0));
      check("b_out_data", b_od, (exp0_q.size() != 0) ? exp0_q[0] : NOP);
      check("b_occupancy", W'(b_occ), W'(exp0_q.size()));
      check("b_in_ready", W'(b_ir), W'((exp0_q.size() == 0) || b_ordy));
   end

   // Directed stimulus with literal expectations
   initial begin
      // 1: reset and release
      tick();
      check("rst_in_ready", W'(a_ir), W'(0));
      check("rst_out_valid", W'(a_ov), W'(0));
      check("rst_out_data", a_od, NOP);
      check("rst_occ", W'(a_occ), W'(0));
      tick();
      rst_in = 1'b0;
      #1;
      check("release_in_ready_low", W'(a_ir), W'(0));
      tick();
      check("release_in_ready_high", W'(a_ir), W'(1));

      // 2: streaming 1..4
      a_ordy = 1'b1;
      a_iv   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_id = W'(i);
         tick();
         check("stream_data", a_od, W'(i));
         check("stream_occ", W'(a_occ), W'(1));
      end
      a_iv = 1'b0;
      tick();
      check("stream_drain_valid", W'(a_ov), W'(0));

      // 3: back-pressure with A, B, then C refused
      a_ordy = 1'b0;
      a_iv   = 1'b1;
      a_id   = W'(32'hA);
      tick();
      check("bp_a_out", a_od, W'(32'hA));
      a_id = W'(32'hB);
      tick();
      check("bp_full_out", a_od, W'(32'hA));
      check("bp_full_occ", W'(a_occ), W'(2));
      check("bp_full_ready", W'(a_ir), W'(0));
      a_id = W'(32'hC);
      tick();
      check("bp_hold_out", a_od, W'(32'hA));
      a_ordy = 1'b1;
      tick();
      check("bp_b_out", a_od, W'(32'hB));
      check("bp_b_occ", W'(a_occ), W'(1));
      a_iv = 1'b0;
      tick();
      check("bp_empty_valid", W'(a_ov), W'(0));
      check("bp_empty_data", a_od, NOP);

      // 4: flush while FULL, with D offered
      a_ordy = 1'b0;
      a_iv   = 1'b1;
      a_id   = W'(32'hA);
      tick();
      a_id = W'(32'hB);
      tick();
      check("fl_pre_occ", W'(a_occ), W'(2));
      a_id    = W'(32'hD);
      a_flush = 1'b1;
      tick();
      check("fl_valid", W'(a_ov), W'(0));
      check("fl_data", a_od, NOP);
      check("fl_occ", W'(a_occ), W'(0));
      check("fl_ready", W'(a_ir), W'(1));
      a_flush = 1'b0;
      a_iv    = 1'b0;
      a_ordy  = 1'b1;
      tick();
      check("fl_no_d", W'(a_ov), W'(0));

      // 5: asynchronous reset while FULL
      a_ordy = 1'b0;
      a_iv   = 1'b1;
      a_id   = W'(32'hA);
      tick();
      a_id = W'(32'hB);
      tick();
      a_iv = 1'b0;
      #2;
      rst_in = 1'b1;
      #1;
      check("arst_valid", W'(a_ov), W'(0));
      check("arst_data", a_od, NOP);
      check("arst_occ", W'(a_occ), W'(0));
      check("arst_ready", W'(a_ir), W'(0));
      tick();
      rst_in = 1'b0;
      tick();
      check("arst_release_ready", W'(a_ir), W'(1));
      a_ordy = 1'b1;
      a_iv   = 1'b1;
      a_id   = W'(5);
      tick();
      check("arst_stream5", a_od, W'(5));
      a_id = W'(6);
      tick();
      check("arst_stream6", a_od, W'(6));
      a_iv = 1'b0;
      tick();
      check("arst_stream_end", W'(a_ov), W'(0));

      // 6: single-slot instance
      b_ordy = 1'b0;
      b_iv   = 1'b1;
      b_id   = W'(3);
      tick();
      check("ss_first", b_od, W'(3));
      check("ss_ready_low", W'(b_ir), W'(0));
      b_id = W'(32'h7);
      tick();
      check("ss_hold", b_od, W'(3));
      check("ss_hold_occ", W'(b_occ), W'(1));
      b_ordy = 1'b1;
      #1;
      check("ss_ready_comb", W'(b_ir), W'(1));
      tick();
      check("ss_seven", b_od, W'(32'h7));
      check("ss_seven_occ", W'(b_occ), W'(1));
      b_iv = 1'b0;
      tick();
      check("ss_empty", W'(b_ov), W'(0));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
